gearbox_20_to_66: RTL and testbench
===================================

// Module: gearbox_20_to_66
// PURPOSE
// - Receive-side gearbox for 64b/66b links: packs a continuous 20-bit/cycle lane into 66-bit blocks.
// - Optional bit-slip alignment finds the 2-bit sync header. Sits between the SERDES parallel output and the descrambler/decoder.
// - Average output rate is 10 blocks per 33 clocks.
// PARAMETERS
// - LOCK_GOOD_CNT  32  consecutive valid headers needed to assert locked (LOCK_STATUS_EN only)
// PORTS
// - clk            in   1   single clock, all logic rising-edge
// - sclr           in   1   reset; one clock; reset is asynchronous and active-high
// - slip_to_frame  in   1   1 = hunt for sync header via bit slip; 0 = free-run, never slip
// - din            in   20  lane data, din[0] is the oldest bit
// - dout           out  66  block, dout[0] oldest bit, dout[1:0] = sync header
// - dout_valid     out  1   one-cycle strobe qualifying dout
// - word_locked    out  1   only present when LOCK_STATUS_EN is defined
// BEHAVIOUR
// - State: bit buffer buf[85:0] (LSB oldest), fill count cnt (0..85), slip_pend flag.
// - Every clock, din is appended above the valid bits:
//   comb = buf | (din << cnt); n = cnt + 20.
// - If slip_pend is set: comb = comb >> 1, n = n - 1, and slip_pend clears.
// - If n >= 66: dout <= comb[65:0], dout_valid <= 1, buf <= comb >> 66, cnt <= n - 66.
// - Else: dout_valid <= 0, dout holds, buf <= comb, cnt <= n.
// - Bits above cnt in buf are always zero. Mask on shift so no stale bits OR in.
// - Latency: the cycle in which the 66th bit arrives, dout/dout_valid are registered; they are visible the next clock.
// - Without slips, dout_valid is high exactly 10 of every 33 cycles; the pattern repeats every 33 cycles.
// - Header check: a header is good iff dout[1:0] is 2'b01 or 2'b10. 2'b00 and 2'b11 are bad.
// - Slip: when dout_valid is high, slip_to_frame is 1 and the header is bad, set slip_pend. This discards exactly one bit on the next cycle.
// - At most one slip per emitted block. When slip_to_frame is 0, slip_pend never sets.
// - Slipping reduces n by 1, so the block that would have been emitted may be delayed one cycle. This is permitted.
// - Reset (async assert, any time including mid-block): buf = 0, cnt = 0, slip_pend = 0, dout = 0, dout_valid = 0, word_locked = 0.
// - Partial data is discarded. The first block after deassert completes on the 4th clock (20 bits x 4 >= 66).
// - No backpressure: the downstream consumer must accept every dout_valid strobe.
// CONFIGURATION
// - Macro GEARBOX_LOCK_STATUS_EN.
// - Defined: adds port word_locked. A good-header counter increments on each valid good header.
//   word_locked sets when the counter reaches LOCK_GOOD_CNT. Any valid bad header clears the counter and word_locked on the same edge.
// - Not defined: no word_locked port and no counter logic; all other behaviour is identical.
// STRUCTURE
// - Package gearbox_pkg:
//   - LANE_W = 20, BLK_W = 66, BUF_W = 86
//   - SH_DATA = 2'b10, SH_CTRL = 2'b01
//   - function sh_good(logic [1:0])
// - Sub-module gearbox_lock_mon (header counter + word_locked), instantiated only under GEARBOX_LOCK_STATUS_EN.
// - Top holds the buffer, fill count and slip logic.
// TESTING
// - Reset: hold sclr 5 clks, release with din = 0 -> dout_valid 0 for 3 clks; first strobe after the 4th din cycle; dout = 0.
// - Rate: slip_to_frame = 0, free-running din -> exactly 10 dout_valid strobes in every 33-clock window.
// - Aligned loopback: a matching 66->20 transmit gearbox feeds blocks {payload, 2'b10} with payload rotating left 1 bit per block, 0-bit offset.
//   Required: header 2'b10 on every block from the first, and no slips.
// - Misaligned loopback: same stream delayed by 3 bits, slip_to_frame = 1.
//   Required: within 1000 clks, each block == previous block's payload rotated by 1 with header 2'b10, sustained thereafter.
// - Slip gating: same 3-bit offset with slip_to_frame = 0 -> alignment never changes; bad headers persist.
// - Async reset mid-block: assert sclr between clock edges with cnt = 40 -> outputs clear immediately.
//   After release, alignment is re-acquired as in the misaligned loopback case.
// - GEARBOX_LOCK_STATUS_EN, LOCK_GOOD_CNT = 32: word_locked rises after the 32nd consecutive good header.
//   Injecting one 2'b11 header drops word_locked on the same edge.

Source files
------------

// File: rtl/gearbox_pkg.sv
// Shared constants and helpers for the 20->66 receive gearbox.
// Contents: lane/block/buffer widths, sync-header encodings, header check.
package gearbox_pkg;

    localparam int unsigned LANE_W = 20;
    localparam int unsigned BLK_W  = 66;
    localparam int unsigned BUF_W  = 86;
    // Fill count never exceeds 85, so 7 bits are enough.
    localparam int unsigned CNT_W  = 7;

    typedef logic [1:0] sh_t;

    localparam sh_t SH_DATA = 2'b10;
    localparam sh_t SH_CTRL = 2'b01;

    // A sync header is valid only when its two bits differ.
    function automatic logic sh_good(input sh_t sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/gearbox_lock_mon.sv
// Header lock monitor: counts consecutive good sync headers on emitted blocks.
// Ports:
//   clk, sclr    - clock, asynchronous active-high reset
//   blk_valid    - a block is being registered on this edge
//   blk_hdr      - sync header of that block
//   word_locked  - high once LOCK_GOOD_CNT consecutive good headers are seen;
//                  cleared on the same edge as any bad header
module gearbox_lock_mon
    import gearbox_pkg::*;
#(
    parameter int unsigned LOCK_GOOD_CNT = 32
)
(
    input  logic clk,
    input  logic sclr,
    input  logic blk_valid,
    input  sh_t  blk_hdr,
    output logic word_locked
);

    localparam int unsigned GW = $clog2(LOCK_GOOD_CNT + 1);

    logic [GW-1:0] good_cnt;

    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            good_cnt    <= '0;
            word_locked <= 1'b0;
        end else if (blk_valid) begin
            if (sh_good(blk_hdr)) begin
                // Saturate so a long good run cannot wrap and drop lock.
                if (good_cnt != GW'(LOCK_GOOD_CNT))
                    good_cnt <= good_cnt + GW'(1);
                if (good_cnt >= GW'(LOCK_GOOD_CNT - 1))
                    word_locked <= 1'b1;
            end else begin
                good_cnt    <= '0;
                word_locked <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gearbox_20_to_66.sv
// Receive gearbox: packs a continuous 20-bit lane into 66-bit 64b/66b blocks,
// with optional bit-slip hunting for the 2-bit sync header.
// Optional feature macro: GEARBOX_LOCK_STATUS_EN (adds word_locked port).
// Ports:
//   clk           - clock, rising edge
//   sclr          - asynchronous active-high reset
//   slip_to_frame - 1: slip one bit after each bad header; 0: free-run
//   din[19:0]     - lane data, din[0] oldest
//   dout[65:0]    - block, dout[0] oldest, dout[1:0] sync header
//   dout_valid    - one-cycle strobe qualifying dout
//   word_locked   - header lock status (GEARBOX_LOCK_STATUS_EN only)
module gearbox_20_to_66
    import gearbox_pkg::*;
#(
    parameter int unsigned LOCK_GOOD_CNT = 32
)
(
    input  logic              clk,
    input  logic              sclr,
    input  logic              slip_to_frame,
    input  logic [LANE_W-1:0] din,
    output logic [BLK_W-1:0]  dout,
    output logic              dout_valid
`ifdef GEARBOX_LOCK_STATUS_EN
    ,
    output logic              word_locked
`endif
);

    localparam logic [CNT_W-1:0] LANE_N = CNT_W'(LANE_W);
    localparam logic [CNT_W-1:0] BLK_N  = CNT_W'(BLK_W);

    logic [BUF_W-1:0] bit_buf;   // valid bits at [cnt-1:0], zeros above
    logic [CNT_W-1:0] cnt;
    logic             slip_pend;

    logic [BUF_W-1:0] comb;
    logic [CNT_W-1:0] n;
    logic             emit;

    always_comb begin
        comb = bit_buf | (BUF_W'(din) << cnt);
        n    = cnt + LANE_N;
        // A pending slip drops the oldest bit of the combined word.
        if (slip_pend) begin
            comb = comb >> 1;
            n    = n - CNT_W'(1);
        end
        emit = (n >= BLK_N);
    end

    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            bit_buf    <= '0;
            cnt        <= '0;
            slip_pend  <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            // Judged on the registered block, so at most one slip per block.
            slip_pend <= dout_valid && slip_to_frame && !sh_good(dout[1:0]);
            if (emit) begin
                dout       <= comb[BLK_W-1:0];
                dout_valid <= 1'b1;
                bit_buf    <= comb >> BLK_W;
                cnt        <= n - BLK_N;
            end else begin
                dout_valid <= 1'b0;
                bit_buf    <= comb;
                cnt        <= n;
            end
        end
    end

`ifdef GEARBOX_LOCK_STATUS_EN
    // Fed with the block being registered so lock tracks dout on the same edge.
    gearbox_lock_mon #(
        .LOCK_GOOD_CNT(LOCK_GOOD_CNT)
    ) u_lock_mon (
        .clk        (clk),
        .sclr       (sclr),
        .blk_valid  (emit),
        .blk_hdr    (comb[1:0]),
        .word_locked(word_locked)
    );
`else
    // Lock threshold has no effect without the status port.
    if (LOCK_GOOD_CNT == 0) begin : g_no_lock_mon
    end
`endif

endmodule

// File: tb/tb_gearbox_20_to_66.sv
`timescale 1ns/1ps
module tb_gearbox_20_to_66;

    logic        clk = 1'b0;
    logic        sclr = 1'b1;
    logic        slip_to_frame = 1'b0;
    logic [19:0] din = '0;
    logic [65:0] dout;
    logic        dout_valid;
`ifdef GEARBOX_LOCK_STATUS_EN
    logic        word_locked;
`endif

    always #5 clk = ~clk;

    gearbox_20_to_66 #(.LOCK_GOOD_CNT(32)) dut (
        .clk          (clk),
        .sclr         (sclr),
        .slip_to_frame(slip_to_frame),
        .din          (din),
        .dout         (dout),
        .dout_valid   (dout_valid)
`ifdef GEARBOX_LOCK_STATUS_EN
        ,
        .word_locked  (word_locked)
`endif
    );

    int vecs = 0;
    int errs = 0;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain bit queue, oldest bit at the front.
    bit          mq[$];
    bit          m_slip;
    logic [65:0] m_dout;
    bit          m_valid;
    int          m_good;
    bit          m_locked;

    task automatic model_reset();
        mq.delete();
        m_slip = 0; m_dout = '0; m_valid = 0; m_good = 0; m_locked = 0;
    endtask

    task automatic model_step(input logic [19:0] d, input logic stf);
        bit ns;
        ns = m_valid && stf && (m_dout[0] == m_dout[1]);
        for (int i = 0; i < 20; i++) mq.push_back(d[i]);
        if (m_slip) void'(mq.pop_front());
        if (mq.size() >= 66) begin
            for (int i = 0; i < 66; i++) m_dout[i] = mq.pop_front();
            m_valid = 1;
            if (m_dout[0] != m_dout[1]) begin
                m_good++;
                if (m_good >= 32) m_locked = 1;
            end else begin
                m_good = 0;
                m_locked = 0;
            end
        end else begin
            m_valid = 0;
        end
        m_slip = ns;
    endtask

    task automatic cycle(input logic [19:0] d, input logic stf);
        din = d;
        slip_to_frame = stf;
        @(posedge clk);
        model_step(d, stf);
        #1;
        check("valid", {65'b0, dout_valid}, {65'b0, m_valid});
        check("dout", dout, m_dout);
`ifdef GEARBOX_LOCK_STATUS_EN
        check("locked", {65'b0, word_locked}, {65'b0, m_locked});
`endif
    endtask

    task automatic do_reset(input int hold);
        sclr = 1'b1;
        din = '0;
        slip_to_frame = 1'b0;
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("rst_valid", {65'b0, dout_valid}, 66'd0);
            check("rst_dout", dout, 66'd0);
        end
        sclr = 1'b0;
        model_reset();
    endtask

    // Transmit-side 66->20 gearbox: blocks {payload, 2'b10}, payload rotates left by 1.
    bit          tx_q[$];
    logic [63:0] tx_pl;
    int          tx_blk;
    int          tx_inject;
    logic [65:0] exp_blk[$];

    function automatic logic [63:0] rotl(input logic [63:0] p);
        return {p[62:0], p[63]};
    endfunction

    task automatic tx_start(input int offset, input int inject);
        tx_q.delete();
        exp_blk.delete();
        for (int i = 0; i < offset; i++) tx_q.push_back(1'($urandom));
        tx_pl = {$urandom, $urandom};
        tx_blk = 0;
        tx_inject = inject;
    endtask

    task automatic tx_word(output logic [19:0] w);
        logic [65:0] blk;
        while (tx_q.size() < 20) begin
            blk = {tx_pl, (tx_blk == tx_inject) ? 2'b11 : 2'b10};
            for (int i = 0; i < 66; i++) tx_q.push_back(blk[i]);
            exp_blk.push_back(blk);
            tx_pl = rotl(tx_pl);
            tx_blk++;
        end
        for (int i = 0; i < 20; i++) w[i] = tx_q.pop_front();
    endtask

    typedef struct {
        logic [19:0] d;
        logic        v;
        logic [65:0] o;
    } vec_t;

    vec_t        tbl[7];
    logic [19:0] w;
    logic [65:0] prev;
    logic [65:0] eb;
    int          win_cnt, run, bad_cnt, blk_seen;
    bit          acq, have_prev;

    initial begin
        tbl[0] = '{20'h00001, 1'b0, 66'd0};
        tbl[1] = '{20'h00002, 1'b0, 66'd0};
        tbl[2] = '{20'h00003, 1'b0, 66'd0};
        tbl[3] = '{20'h0003F, 1'b1, {6'h3F, 20'h00003, 20'h00002, 20'h00001}};
        tbl[4] = '{20'hFFFFF, 1'b0, {6'h3F, 20'h00003, 20'h00002, 20'h00001}};
        tbl[5] = '{20'h00000, 1'b0, {6'h3F, 20'h00003, 20'h00002, 20'h00001}};
        tbl[6] = '{20'h00000, 1'b1, 66'hFFFFF << 14};

        // Reset and first-block latency with hand-computed blocks.
        do_reset(5);
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].d, 1'b0);
            check("tbl_valid", {65'b0, dout_valid}, {65'b0, tbl[i].v});
            check("tbl_dout", dout, tbl[i].o);
        end

        // Free-running rate: 10 strobes in every 33-clock window.
        for (int win = 0; win < 10; win++) begin
            win_cnt = 0;
            for (int c = 0; c < 33; c++) begin
                cycle(20'($urandom), 1'b0);
                if (dout_valid) win_cnt++;
            end
            check("rate_win", 66'(win_cnt), 66'd10);
        end

        // Random data with random slip enable, checked cycle-by-cycle.
        for (int c = 0; c < 200; c++) cycle(20'($urandom), 1'($urandom_range(0, 1)));

        // Aligned loopback: every block is the transmitted one, no slips.
        do_reset(3);
        tx_start(0, -1);
        for (int c = 0; c < 300; c++) begin
            tx_word(w);
            cycle(w, 1'b1);
            if (dout_valid) begin
                eb = exp_blk.pop_front();
                check("aligned_blk", dout, eb);
            end
        end

        // Async reset mid-block: 35 cycles after reset leaves cnt = 40.
        do_reset(3);
        for (int c = 0; c < 35; c++) cycle(20'($urandom), 1'b0);
        #3;
        sclr = 1'b1;
        #1;
        check("async_valid", {65'b0, dout_valid}, 66'd0);
        check("async_dout", dout, 66'd0);
        do_reset(3);

        // Misaligned loopback by 3 bits with slipping: must acquire and hold.
        tx_start(3, -1);
        acq = 0; run = 0; have_prev = 0;
        for (int c = 0; c < 1000; c++) begin
            tx_word(w);
            cycle(w, 1'b1);
            if (dout_valid) begin
                if (acq) begin
                    check("mis_hdr", {64'b0, dout[1:0]}, 66'd2);
                    check("mis_rot", {2'b0, dout[65:2]}, {2'b0, rotl(prev[65:2])});
                end else begin
                    if (dout[1:0] == 2'b10 && have_prev && dout[65:2] == rotl(prev[65:2])) run++;
                    else run = 0;
                    if (run >= 8) acq = 1;
                end
                prev = dout;
                have_prev = 1;
            end
        end
        check("mis_acquired", {65'b0, acq}, 66'd1);

        // Slip gating: same offset, slipping disabled, bad headers keep appearing.
        do_reset(3);
        tx_start(3, -1);
        bad_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            tx_word(w);
            cycle(w, 1'b0);
            if (dout_valid && dout[0] == dout[1]) bad_cnt++;
        end
        check("gating_bad_seen", {65'b0, bad_cnt > 10}, 66'd1);

`ifdef GEARBOX_LOCK_STATUS_EN
        // Lock after 32 good headers; one 2'b11 header (41st block) drops it.
        do_reset(3);
        tx_start(0, 40);
        blk_seen = 0;
        for (int c = 0; c < 200; c++) begin
            tx_word(w);
            cycle(w, 1'b0);
            if (dout_valid) begin
                blk_seen++;
                if (blk_seen == 31) check("lock_31", {65'b0, word_locked}, 66'd0);
                if (blk_seen == 32) check("lock_32", {65'b0, word_locked}, 66'd1);
                if (blk_seen == 41) check("lock_bad", {65'b0, word_locked}, 66'd0);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
